// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: pc_src selects, opcodes, fetch FSM states.
package cpu_pkg;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JR     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_JR   = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [31:0] HALT_INSTR = {OP_HALT, 26'b0};

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_READY = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - combinational next-PC select and pc+4 adder.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs_data,
  input  logic [31:0] ir,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    case (pc_src)
      PCSRC_PLUS4:  next_pc = pc_plus4;
      PCSRC_BRANCH: next_pc = pc_plus4 + (imm_ext << 2);
      PCSRC_JR:     next_pc = rs_data & 32'hFFFF_FFFC;
      // Jump keeps the region bits of pc+4 and the word index from ir[25:0].
      PCSRC_JUMP:   next_pc = {pc_plus4[31:28], 28'(ir << 2)};
      default:      next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IR and req/ack imem handshake.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_wre,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs_data,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic [5:0]  op,
  output logic        ir_valid,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fetch_state_t state;
  logic [31:0]  next_pc;

  next_pc_mux u_next_pc_mux (
    .pc       (pc),
    .pc_src   (pc_src),
    .imm_ext  (imm_ext),
    .rs_data  (rs_data),
    .ir       (ir),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  assign imem_addr = pc;
  assign op        = ir[31:26];

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      imem_req <= 1'b0;
      ir_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt    <= '0;
      fetch_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          // Only the edge right after reset sees req low; raise it without sampling ack.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            ir_valid <= 1'b1;
            state    <= ST_READY;
`ifdef FETCH_TIMEOUT_EN
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            ir        <= HALT_INSTR;
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            ir_valid  <= 1'b1;
            state     <= ST_READY;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        ST_READY: begin
          if (pc_wre) begin
            pc       <= next_pc;
            ir_valid <= 1'b0;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a reference PC/IR model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_wre;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [31:0] rs_data;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ir;
  logic [5:0]  op;
  logic        ir_valid;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;

  fetch_unit #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_wre     (pc_wre),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .rs_data    (rs_data),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ir         (ir),
    .op         (op),
    .ir_valid   (ir_valid),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rules written as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [1:0] src, input logic [31:0] cur_pc,
                                             input logic [31:0] cur_ir, input logic [31:0] imm,
                                             input logic [31:0] rs);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    case (src)
      2'd0:    return seq;
      2'd1:    return seq + imm * 32'd4;
      2'd2:    return rs - (rs % 32'd4);
      default: return (seq & 32'hF000_0000) | ((cur_ir % 32'h0400_0000) * 32'd4);
    endcase
  endfunction

  // Expects FETCH with req already high; k wait edges, then an ack edge.
  task automatic do_fetch(input int k, input logic [31:0] data);
    for (int i = 0; i < k; i++) begin
      imem_ack   = 1'b0;
      pc_wre     = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      tick();
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, m_pc);
      check("wait_valid", 32'(ir_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    pc_wre     = 1'($urandom_range(0, 1));
    tick();
    imem_ack = 1'b0;
    pc_wre   = 1'b0;
    m_ir     = data;
    check("ack_ir", ir, m_ir);
    check("ack_op", 32'(op), 32'(m_ir >> 26));
    check("ack_valid", 32'(ir_valid), 32'd1);
    check("ack_req", 32'(imem_req), 32'd0);
    check("ack_pc", pc, m_pc);
  endtask

  // Expects READY; spurious ack first, then one pc_wre edge.
  task automatic advance(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] rs);
    logic [31:0] exp;
    imem_ack   = 1'b1;
    imem_rdata = ~m_ir;
    tick();
    imem_ack = 1'b0;
    check("spur_ir", ir, m_ir);
    check("spur_valid", 32'(ir_valid), 32'd1);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    pc_src  = src;
    imm_ext = imm;
    rs_data = rs;
    pc_wre  = 1'b1;
    exp     = model_next(src, m_pc, m_ir, imm, rs);
    tick();
    pc_wre = 1'b0;
    m_pc   = exp;
    check("adv_pc", pc, m_pc);
    check("adv_addr", imem_addr, m_pc);
    check("adv_req", 32'(imem_req), 32'd1);
    check("adv_valid", 32'(ir_valid), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc  = RESET_PC;
    m_ir  = '0;
    check("rst_pc", pc, RESET_PC);
    check("rst_ir", ir, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    reset      = 1'b1;
    pc_wre     = 1'b0;
    pc_src     = 2'd0;
    imm_ext    = '0;
    rs_data    = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    m_pc       = RESET_PC;
    m_ir       = '0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    do_fetch(2, 32'h0800_0004);
    check("first_op", 32'(op), 32'h02);
    advance(2'b11, 32'd0, 32'd0);
    check("jump_0x10", pc, 32'h0000_0010);
    do_fetch(1, $urandom);
    advance(2'b01, 32'hFFFF_FFFE, 32'd0);
    check("branch_back", pc, 32'h0000_000C);
    do_fetch(0, $urandom);
    advance(2'b10, 32'd0, 32'h0000_0043);
    check("jr_align", pc, 32'h0000_0040);
    do_fetch(0, $urandom);
    advance(2'b10, 32'd0, 32'hF000_0000);
    do_fetch(1, 32'h0800_0010);
    advance(2'b11, 32'd0, 32'd0);
    check("jump_region", pc, 32'hF000_0040);
    do_fetch(0, $urandom);
    advance(2'b10, 32'd0, 32'hFFFF_FFFF);
    do_fetch(3, $urandom);
    advance(2'b00, 32'd0, 32'd0);
    check("plus4_wrap", pc, 32'h0000_0000);
    do_fetch(0, $urandom);
    advance(2'b10, 32'd0, 32'h0000_0020);

    // Reset in the middle of a pending fetch.
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_pc", pc, RESET_PC);
    @(posedge clk);
    #1;
    apply_reset();
    do_fetch(1, $urandom);

    for (int it = 0; it < 24; it++) begin
      logic [1:0]  src;
      logic [31:0] imm;
      src = 2'($urandom_range(0, 3));
      imm = 32'($urandom_range(0, 64)) - 32'd32;
      advance(src, imm, $urandom);
      do_fetch($urandom_range(0, 3), $urandom);
    end
    advance(2'b00, 32'd0, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_valid", 32'(ir_valid), 32'd0);
    end
    tick();
    check("to_op", 32'(op), 32'h3F);
    check("to_err", 32'(fetch_err), 32'd1);
    check("to_valid", 32'(ir_valid), 32'd1);
    check("to_req", 32'(imem_req), 32'd0);
    repeat (3) tick();
    check("to_sticky", 32'(fetch_err), 32'd1);
    apply_reset();
    do_fetch(3, 32'h1234_5678);
    check("ack_wins_err", 32'(fetch_err), 32'd0);
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      check("nto_req", 32'(imem_req), 32'd1);
      check("nto_valid", 32'(ir_valid), 32'd0);
    end
    check("nto_err", 32'(fetch_err), 32'd0);
    do_fetch(0, 32'hFC00_0000);
    check("halt_op", 32'(op), 32'h3F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
